serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first.
- Uses a full-subtractor cell and a borrow flop; the arithmetic inverse of the team's half-adder/adder blocks.
- Start/ready handshake on input, one-cycle done pulse on output.
- Intended as a small-area arithmetic unit for the day-series datapath blocks and as a sequential companion to the combinational adders.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-position counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational full subtractor: d = a - b - bin, bout set on underflow.
// Two half-subtractor stages with their borrows ORed.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First stage: a - b
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // Second stage: (a - b) - bin
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned A - B, LSB first, one bit per clock.
// Accept on start while in_ready; result and done pulse WIDTH cycles later.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             bw_nx;
    logic             d;
    logic             last;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bw),
        .d    (d),
        .bout (bw_nx)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    // New result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_nx = (res >> 1) | {d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SHIFT;
            ST_SHIFT: if (last)  state_nx = ST_DONE;
            ST_DONE:             state_nx = ST_IDLE;
            default:             state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: busy     = 1'b1;
            ST_DONE:  done     = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            bw     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        bw   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_nx;
                    bw   <= bw_nx;
                    // Hold cnt on the final bit so it never wraps mid-operation.
                    if (last) begin
                        diff   <= res_nx;
                        borrow <= bw_nx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timeline/arithmetic model checked every cycle,
// plus directed literal expectations.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] diff;
    logic         in_ready;
    logic         borrow;
    logic         busy;
    logic         done;

    int tests     = 0;
    int fails     = 0;
    int dut_dones = 0;
    int m_dones   = 0;

    // Model: ph=0 idle, 1..W shifting, W+1 done cycle.
    int           ph = 0;
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] m_diff;
    logic         m_borrow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .diff     (diff),
        .borrow   (borrow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph       <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ma <= A;
                mb <= B;
                ph <= 1;
            end
        end else if (ph == W) begin
            m_diff   <= ma - mb;
            m_borrow <= (ma < mb);
            m_dones  <= m_dones + 1;
            ph       <= W + 1;
        end else if (ph == W + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(ph == 0));
        chk("busy",     32'(busy),     32'(ph >= 1 && ph <= W));
        chk("done",     32'(done),     32'(ph == W + 1));
        chk("diff",     32'(diff),     32'(m_diff));
        chk("borrow",   32'(borrow),   32'(m_borrow));
        if (done === 1'b1 && rst === 1'b0) dut_dones++;
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb);
        int n;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        wait_done(n);
        chk("latency", 32'(n), 32'(8));
        chk("op_diff", 32'(diff), 32'(ed));
        chk("op_borrow", 32'(borrow), 32'(eb));
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] re;

        rst   = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_busy",     32'(busy),     32'(0));
        chk("rst_done",     32'(done),     32'(0));
        chk("rst_diff",     32'(diff),     32'(0));
        chk("rst_borrow",   32'(borrow),   32'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd5,   8'd3,   8'h02, 1'b0);
        run_op(8'd3,   8'd5,   8'hFE, 1'b1);
        run_op(8'h00,  8'hFF,  8'h01, 1'b1);
        run_op(8'hFF,  8'hFF,  8'h00, 1'b0);

        // Extra start pulses during SHIFT and DONE must be ignored.
        run_op(8'd5, 8'd3, 8'h02, 1'b0);
        A = 8'd9;
        B = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'h33;
        B = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_diff", 32'(diff), 32'h02);
        wait_done(n);
        chk("ign_latency", 32'(n), 32'(5));
        chk("ign_diff", 32'(diff), 32'h08);
        A = 8'h44;
        B = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_after_done", 32'(busy), 32'(0));

        // start held: accepts at edges 0,10,20; done seen after edges 8,18,28.
        A = 8'h20;
        B = 8'h07;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("held_done", 32'(done), 32'(i % 10 == 8));
            chk("held_rdy", 32'(in_ready), 32'(i % 10 == 9));
        end
        start = 1'b0;
        chk("held_diff", 32'(diff), 32'h19);
        @(negedge clk);

        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            re = ra - rb;
            run_op(ra, rb, re, ra < rb);
        end

        // Reset in the middle of an operation.
        run_op(8'h10, 8'h01, 8'h0F, 1'b0);
        A = 8'h77;
        B = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'(1));
        chk("arst_busy",     32'(busy),     32'(0));
        chk("arst_done",     32'(done),     32'(0));
        chk("arst_diff",     32'(diff),     32'(0));
        chk("arst_borrow",   32'(borrow),   32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'd9, 8'd4, 8'h05, 1'b0);
        repeat (3) @(negedge clk);

        chk("done_vs_model", 32'(dut_dones), 32'(m_dones));
        chk("done_total", 32'(dut_dones), 32'(1011));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
